fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 128 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream synchronous FIFO.
// One byte per frame: IDLE -> POP -> LOAD -> START -> DATA x8 -> STOP -> IDLE.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        baud_done;

  assign baud_done = (baud_q == BaudMax);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_count_d = byte_count_q;
    tx_d         = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d = fifo_rdata;
        state_d = StStart;
      end
      StStart: begin
        if (baud_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            baud_d    = '0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_done) begin
          state_d      = StIdle;
          byte_count_d = byte_count_q + 16'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      baud_d = '0;
    end

    // tx is derived from the next state so the line level is registered
    // and only moves on bit boundaries.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign fifo_read  = (state_q == StPop);
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based sfifo model plus a per-cycle frame-timing
// reference model, driven by directed and randomized traffic.
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int FrameCycles = 10 * C + 2;  // POP + LOAD + 10 bit times

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_read;
  logic        tx;
  logic        busy;
  logic [15:0] byte_count;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] sfifo[$];      // contents of the upstream FIFO
  logic [7:0] exp_q[$];      // bytes the model expects to send, in order
  int         pop_times[$];

  // Reference model: ph = -1 when idle, else cycles elapsed since the pop cycle.
  int          ph = -1;
  logic [7:0]  cur_byte = 8'h00;
  logic [15:0] m_cnt = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_tx(input int p, input logic [7:0] b);
    logic [9:0] frame;
    int idx;
    frame = {1'b1, b, 1'b0};
    if (p < 2 || p >= FrameCycles) return 1'b1;
    idx = (p - 2) / C;
    return frame[idx];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    sfifo.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_fifo();
    sfifo.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle checker: inputs are stable at the edge (driven on negedges),
  // outputs are compared 1 time unit after it.
  always begin
    logic s_rst, s_en, s_empty;
    @(posedge clk);
    s_rst   = rst;
    s_en    = enable;
    s_empty = fifo_empty;
    if (s_rst) begin
      ph    = -1;
      m_cnt = 16'h0000;
    end else if (ph == -1) begin
      if (s_en && !s_empty) begin
        ph = 0;
        cur_byte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      end
    end else begin
      ph++;
      if (ph == FrameCycles) begin
        ph    = -1;
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
    cyc++;
    check_eq("fifo_read", 32'(fifo_read), 32'(ph == 0));
    check_eq("busy", 32'(busy), 32'(ph != -1));
    check_eq("tx", 32'(tx), 32'(model_tx(ph, cur_byte)));
    check_eq("byte_count", 32'(byte_count), 32'(m_cnt));
    if (fifo_read) begin
      check_eq("read_nonempty", 32'(sfifo.size() != 0), 32'd1);
      pop_times.push_back(cyc);
      if (sfifo.size() != 0) fifo_rdata = sfifo.pop_front();
      fifo_empty = (sfifo.size() == 0);
    end
  end

  logic [9:0] a5_frame;

  initial begin
    a5_frame = 10'b1101001010;

    // Reset
    cycles(3);
    rst = 1'b0;
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_count", 32'(byte_count), 32'd0);

    // Gating: enabled but empty, then data queued but disabled
    enable = 1'b1;
    cycles(50);
    enable = 1'b0;
    push_byte(8'hA5);
    cycles(50);
    check_eq("gate_fifo_kept", 32'(sfifo.size()), 32'd1);

    // Single byte 0xA5 checked against the literal line waveform
    enable = 1'b1;
    cycles(3);  // now in the first START cycle
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < C; j++) begin
        check_eq("a5_wave", 32'(tx), 32'(a5_frame[i]));
        @(negedge clk);
      end
    end
    cycles(5);
    check_eq("a5_count", 32'(byte_count), 32'd1);
    check_eq("a5_pops", 32'(pop_times.size()), 32'd1);

    // Burst of 20 bytes
    pop_times.delete();
    for (int i = 1; i <= 20; i++) push_byte(8'(i));
    cycles(20 * (10 * C + 3) + 10);
    check_eq("burst_pops", 32'(pop_times.size()), 32'd20);
    for (int i = 1; i < pop_times.size(); i++)
      check_eq("burst_spacing", 32'(pop_times[i] - pop_times[i-1]), 32'(10 * C + 3));
    check_eq("burst_empty", 32'(sfifo.size()), 32'd0);
    check_eq("burst_count", 32'(byte_count), 32'd21);

    // Enable drop mid-frame with 3 bytes queued
    push_byte(8'(($urandom & 32'hFF)));
    push_byte(8'(($urandom & 32'hFF)));
    push_byte(8'(($urandom & 32'hFF)));
    cycles(10);  // inside DATA
    enable = 1'b0;
    cycles(60);
    check_eq("drop_remaining", 32'(sfifo.size()), 32'd2);
    check_eq("drop_count", 32'(byte_count), 32'd22);

    // Reset pulse during data bit 4
    enable = 1'b1;
    cycles(24);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(byte_count), 32'd0);
    cycles(60);
    check_eq("rst_next_count", 32'(byte_count), 32'd1);
    check_eq("rst_next_empty", 32'(sfifo.size()), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0 && sfifo.size() < 8) push_byte(8'($urandom));
      @(negedge clk);
    end
    rst    = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 12 * C + 10 && ph != -1; i++) @(negedge clk);
    check_eq("rand_settled", 32'(ph == -1), 32'd1);
    clear_fifo();
    cycles(2);

    // byte_count wrap
    force dut.byte_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.byte_count_q;
    @(negedge clk);
    check_eq("wrap_preload", 32'(byte_count), 32'hFFFF);
    push_byte(8'h3C);
    enable = 1'b1;
    cycles(FrameCycles + 5);
    check_eq("wrap_count", 32'(byte_count), 32'h0000);
    check_eq("wrap_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
